// File: rtl/dff_serial_sequencer.sv
// dff_serial_sequencer: parallel-in / serial-out word sequencer.
// Takes a WIDTH-bit word over a valid/ready handshake and emits it one bit
// per enabled clock on sout/sout_valid, then pulses done for one cycle.
// Optional feature macro: DFF_SEQ_PARITY_EN appends an odd-parity bit
// (~^word) after the data bits, in its own PAR state.
//
// Handshake: a word is accepted on a rising edge where load_valid and
// load_ready are both high. load_ready is high only in IDLE and never during
// reset. load_data is sampled only on that edge. A word cannot be withdrawn
// by the sequencer once it has been accepted.
// shift_en is the consumer's enable: a rising edge with shift_en=1 consumes
// the bit currently on sout. With shift_en=0 the same bit is presented again.
module dff_serial_sequencer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef DFF_SEQ_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd3
  } state_t;
`endif

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic [CW-1:0]    count;
  logic             out_bit;
  logic             accept;
  logic             consume;

`ifdef DFF_SEQ_PARITY_EN
  logic             par_bit;
`endif

  assign accept    = (state == IDLE) && load_valid && !rst;
  assign consume   = (state == SHIFT) && shift_en;
  assign state_dbg = state;

  // Select the output end of the shift register and move the word toward it.
  always_comb begin
    shreg_shifted = shreg;
    out_bit       = 1'b0;
    if (MSB_FIRST) begin
      out_bit       = shreg[WIDTH-1];
      shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      out_bit       = shreg[0];
      shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_n    = state;
    load_ready = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        load_ready = !rst;
        if (load_valid) state_n = SHIFT;
      end
      SHIFT: begin
        sout       = out_bit;
        sout_valid = 1'b1;
        if (shift_en && (count == LAST)) begin
`ifdef DFF_SEQ_PARITY_EN
          state_n = PAR;
`else
          state_n = DONE;
`endif
        end
      end
`ifdef DFF_SEQ_PARITY_EN
      PAR: begin
        sout       = par_bit;
        sout_valid = 1'b1;
        if (shift_en) state_n = DONE;
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // Word datapath: capture on accept, shift and count on each consumed bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      count <= '0;
    end else if (accept) begin
      shreg <= load_data;
      count <= '0;
    end else if (consume) begin
      shreg <= shreg_shifted;
      count <= count + CW'(1);
    end
  end

`ifdef DFF_SEQ_PARITY_EN
  // Odd parity of the accepted word, held until the PAR state sends it.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (accept) begin
      par_bit <= ~^load_data;
    end
  end
`endif

endmodule

// File: tb/tb_dff_serial_sequencer.sv
// Bench for dff_serial_sequencer: an MSB-first and an LSB-first instance
// share one stimulus stream and are compared every cycle against a
// bit-queue reference model of the serial output.
module tb_dff_serial_sequencer;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         shift_en = 1'b0;

  logic m_ready, m_sout, m_valid, m_busy, m_done;
  logic l_ready, l_sout, l_valid, l_busy, l_done;
  logic [1:0] m_state, l_state;

  dff_serial_sequencer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(m_ready), .shift_en(shift_en), .sout(m_sout),
    .sout_valid(m_valid), .busy(m_busy), .done(m_done), .state_dbg(m_state)
  );

  dff_serial_sequencer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(l_ready), .shift_en(shift_en), .sout(l_sout),
    .sout_valid(l_valid), .busy(l_busy), .done(l_done), .state_dbg(l_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: remaining bits of the word in send order, plus phase.
  // phase 0 = waiting for a word, 1 = sending bits, 2 = done pulse.
  logic exp_q_m[$];
  logic exp_q_l[$];
  int   phase = 0;
  int   done_seen = 0;

  task automatic model_update(input logic r, input logic lv, input logic [W-1:0] d, input logic en);
    if (r) begin
      phase = 0;
      exp_q_m.delete();
      exp_q_l.delete();
    end else begin
      case (phase)
        0: if (lv) begin
          for (int i = 0; i < W; i++) begin
            exp_q_m.push_back(d[W-1-i]);
            exp_q_l.push_back(d[i]);
          end
`ifdef DFF_SEQ_PARITY_EN
          exp_q_m.push_back(~^d);
          exp_q_l.push_back(~^d);
`endif
          phase = 1;
        end
        1: if (en) begin
          void'(exp_q_m.pop_front());
          void'(exp_q_l.pop_front());
          if (exp_q_m.size() == 0) phase = 2;
        end
        default: phase = 0;
      endcase
    end
  endtask

  task automatic check_outputs();
    logic e_ready, e_valid, e_busy, e_done, e_sm, e_sl;
    e_ready = (phase == 0) && !rst;
    e_valid = (phase == 1);
    e_busy  = (phase != 0);
    e_done  = (phase == 2);
    e_sm    = (phase == 1) ? exp_q_m[0] : 1'b0;
    e_sl    = (phase == 1) ? exp_q_l[0] : 1'b0;
    check("msb_ready", m_ready, e_ready);
    check("msb_valid", m_valid, e_valid);
    check("msb_busy",  m_busy,  e_busy);
    check("msb_done",  m_done,  e_done);
    check("msb_sout",  m_sout,  e_sm);
    check("lsb_ready", l_ready, e_ready);
    check("lsb_valid", l_valid, e_valid);
    check("lsb_busy",  l_busy,  e_busy);
    check("lsb_done",  l_done,  e_done);
    check("lsb_sout",  l_sout,  e_sl);
    if (e_done) done_seen++;
  endtask

  // ---------------- driver ----------------
  // One clock: drive inputs, advance model at the edge, check mid-cycle.
  task automatic step(input logic r, input logic lv, input logic [W-1:0] d, input logic en);
    rst        = r;
    load_valid = lv;
    load_data  = d;
    shift_en   = en;
    @(posedge clk);
    model_update(r, lv, d, en);
    @(negedge clk);
    check_outputs();
  endtask

  // Send one word. Cycles after the accept are numbered k=1,2,...;
  // shift_en is low for k in [stall_at, stall_at+stall_len); rst pulses at
  // k==abort_at. Returns the k at which done was observed (0 if never).
  task automatic run_word(input logic [W-1:0] d, input int stall_at, input int stall_len,
                          input int abort_at, input bit noise, output int done_k);
    int k;
    int d0;
    logic en;
    done_k = 0;
    d0 = done_seen;
    step(1'b0, 1'b1, d, 1'b1);
    k = 1;
    while (phase != 0) begin
      if (k > 200) begin
        check("timeout", 32'd1, 32'd0);
        break;
      end
      en = !((k >= stall_at) && (k < stall_at + stall_len));
      if (noise && ($urandom_range(0, 3) == 0)) en = 1'b0;
      if (done_seen != d0 && done_k == 0) done_k = k;
      step(k == abort_at, noise ? 1'($urandom_range(0, 1)) : 1'b0, W'($urandom), en);
      k++;
    end
    if (done_seen != d0 && done_k == 0) done_k = k;
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  // ---------------- main ----------------
  int dk;
  int nbits;

  initial begin
`ifdef DFF_SEQ_PARITY_EN
    nbits = W + 1;
`else
    nbits = W;
`endif
    // Reset for two cycles, then release.
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    check("ready_after_reset", m_ready, 1'b1);

    // 8'hA5 with no stalls: done in the cycle after the last bit.
    run_word(8'hA5, 0, 0, 0, 1'b0, dk);
    check("a5_done_cycle", dk, nbits + 1);

    // 8'h01: LSB instance sends 1 then zeros.
    run_word(8'h01, 0, 0, 0, 1'b0, dk);
    check("01_done_cycle", dk, nbits + 1);

    // 8'hF0 with 3 stall cycles on the 2nd bit.
    run_word(8'hF0, 2, 3, 0, 1'b0, dk);
    check("f0_stall_done_cycle", dk, nbits + 4);

    // 8'hFF aborted by reset during the 4th bit: no done.
    run_word(8'hFF, 0, 0, 4, 1'b0, dk);
    check("ff_abort_no_done", dk, 0);

    // Next word restarts cleanly.
    run_word(8'h0F, 0, 0, 0, 1'b0, dk);
    check("0f_done_cycle", dk, nbits + 1);

    // Parity-relevant words.
    run_word(8'h07, 0, 0, 0, 1'b0, dk);
    check("07_done_cycle", dk, nbits + 1);
    run_word(8'h03, 0, 0, 0, 1'b0, dk);
    check("03_done_cycle", dk, nbits + 1);

    // Boundary words.
    run_word(8'h00, 0, 0, 0, 1'b0, dk);
    run_word(8'h80, 0, 0, 0, 1'b0, dk);

    // Random words, random stalls, random load_valid noise while busy,
    // occasional mid-word reset.
    for (int i = 0; i < 40; i++) begin
      int ab;
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, W)) : 0;
      run_word(W'($urandom), int'($urandom_range(1, W)), int'($urandom_range(0, 3)),
               ab, 1'b1, dk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
